// File: rtl/icache_sa.sv
// icache_sa: set-associative instruction cache with on-demand line refill,
// age-based LRU replacement, whole-cache flush and hit/miss counters.
module icache_sa #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SETS   = 8,
  parameter int WAYS   = 4,
  parameter int WORDS  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_valid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_busy,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);
  localparam int BO_W  = $clog2(DATA_W / 8);
  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int AGE_W = $clog2(WAYS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W - BO_W;
  localparam int FC_W  = IDX_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_MREQ, S_REFILL, S_RESP, S_FLUSH
  } state_t;

  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   valid_d [SETS];
  logic [AGE_W-1:0]  age_q [SETS][WAYS];
  logic [AGE_W-1:0]  age_d [SETS][WAYS];
  logic [AGE_W-1:0]  victim_q, victim_d;
  logic [OFF_W-1:0]  beat_q, beat_d;
  logic [FC_W-1:0]   fidx_q, fidx_d;
  logic              cpu_valid_q, cpu_valid_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

  logic [TAG_W-1:0]  tag_mem  [SETS][WAYS];
  logic [DATA_W-1:0] data_mem [SETS][WAYS][WORDS];
  logic [DATA_W-1:0] line_q   [WORDS];

  logic [TAG_W-1:0] a_tag;
  logic [IDX_W-1:0] a_idx;
  logic [OFF_W-1:0] a_word;
  logic             unused_ok;

  assign a_tag     = addr_q[ADDR_W-1 -: TAG_W];
  assign a_idx     = addr_q[BO_W+OFF_W +: IDX_W];
  assign a_word    = addr_q[BO_W +: OFF_W];
  assign unused_ok = ^addr_q[BO_W-1:0];

  logic             hit;
  logic [AGE_W-1:0] hit_way;
  logic [AGE_W-1:0] vict;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    vict    = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[a_idx][w] && tag_mem[a_idx][w] == a_tag) begin
        hit     = 1'b1;
        hit_way = AGE_W'(w);
      end
      if (age_q[a_idx][w] == AGE_W'(WAYS - 1)) vict = AGE_W'(w);
    end
    // descending scan leaves the lowest invalid way selected
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[a_idx][w]) vict = AGE_W'(w);
    end
  end

  logic             beat_we;
  logic             fill_we;
  logic             touch;
  logic [AGE_W-1:0] touch_way;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    valid_d     = valid_q;
    age_d       = age_q;
    victim_d    = victim_q;
    beat_d      = beat_q;
    fidx_d      = fidx_q;
    cpu_valid_d = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    beat_we     = 1'b0;
    fill_we     = 1'b0;
    touch       = 1'b0;
    touch_way   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (flush) begin
          state_d = S_FLUSH;
          fidx_d  = '0;
        end else if (cpu_req) begin
          addr_d  = cpu_addr;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          cpu_rdata_d = data_mem[a_idx][hit_way][a_word];
          cpu_valid_d = 1'b1;
          touch       = 1'b1;
          touch_way   = hit_way;
          hit_cnt_d   = hit_cnt_q + 1'b1;
          state_d     = S_IDLE;
        end else begin
          miss_cnt_d = miss_cnt_q + 1'b1;
          victim_d   = vict;
          mem_req_d  = 1'b1;
          mem_addr_d = {addr_q[ADDR_W-1:BO_W+OFF_W],
                        {(OFF_W+BO_W){1'b0}}};
          state_d    = S_MREQ;
        end
      end
      S_MREQ: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          beat_d    = '0;
          state_d   = S_REFILL;
        end
      end
      S_REFILL: begin
        if (mem_rvalid) begin
          beat_we = 1'b1;
          beat_d  = beat_q + 1'b1;
          if (beat_q == OFF_W'(WORDS - 1)) begin
            fill_we                  = 1'b1;
            valid_d[a_idx][victim_q] = 1'b1;
            touch                    = 1'b1;
            touch_way                = victim_q;
            state_d                  = S_RESP;
          end
        end
      end
      S_RESP: begin
        cpu_rdata_d = line_q[a_word];
        cpu_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      S_FLUSH: begin
        if (fidx_q == FC_W'(SETS)) begin
          state_d = S_IDLE;
        end else begin
          valid_d[fidx_q[IDX_W-1:0]] = '0;
          fidx_d = fidx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // LRU touch: younger ways age by one, touched way becomes newest
    if (touch) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[a_idx][w] < age_q[a_idx][touch_way])
          age_d[a_idx][w] = age_q[a_idx][w] + 1'b1;
      end
      age_d[a_idx][touch_way] = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      victim_q    <= '0;
      beat_q      <= '0;
      fidx_q      <= '0;
      cpu_valid_q <= 1'b0;
      cpu_rdata_q <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= AGE_W'(w);
      end
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      victim_q    <= victim_d;
      beat_q      <= beat_d;
      fidx_q      <= fidx_d;
      cpu_valid_q <= cpu_valid_d;
      cpu_rdata_q <= cpu_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      valid_q     <= valid_d;
      age_q       <= age_d;
    end
  end

  // storage arrays hold no reset; validity lives in valid_q
  always_ff @(posedge clk) begin
    if (beat_we) line_q[beat_q] <= mem_rdata;
    if (fill_we) begin
      tag_mem[a_idx][victim_q] <= a_tag;
      for (int w = 0; w < WORDS; w++) begin
        data_mem[a_idx][victim_q][w] <=
          (w == WORDS - 1) ? mem_rdata : line_q[w];
      end
    end
  end

  assign cpu_valid = cpu_valid_q;
  assign cpu_rdata = cpu_rdata_q;
  assign cpu_busy  = (state_q != S_IDLE);
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_icache_sa.sv
// tb_icache_sa: directed bench for icache_sa with a scripted
// refill memory; beat b of a line is base*(b+1).
module tb_icache_sa;
  localparam int WORDS = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic        cpu_valid;
  logic [31:0] cpu_rdata;
  logic        cpu_busy;
  logic        flush = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  int n_vec = 0;
  int n_err = 0;

  icache_sa dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_valid(cpu_valid), .cpu_rdata(cpu_rdata),
    .cpu_busy(cpu_busy), .flush(flush),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  // drive one fetch and serve any refill; returns observations only
  task automatic fetch(
    input  logic [31:0] a,
    input  logic [31:0] base,
    input  int          ack_wait,
    input  int          gap,
    output int          cyc,
    output logic [31:0] rd,
    output logic [31:0] maddr,
    output bit          missed,
    output bit          stable,
    output bit          ok
  );
    cyc = 0; rd = '0; maddr = '0;
    missed = 0; stable = 1; ok = 0;
    cpu_req = 1'b1; cpu_addr = a;
    tick();
    cpu_req = 1'b0;
    for (int i = 0; i < 20 && !cpu_valid && !mem_req; i++) begin
      tick(); cyc++;
    end
    if (mem_req) begin
      missed = 1;
      maddr = mem_addr;
      for (int i = 0; i < ack_wait; i++) begin
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick(); cyc++;
        if (!mem_req || mem_addr !== maddr) stable = 0;
      end
      mem_rvalid = 1'b0;
      mem_ack = 1'b1;
      tick(); cyc++;
      mem_ack = 1'b0;
      if (mem_req) stable = 0;
      for (int b = 0; b < WORDS; b++) begin
        for (int g = 0; g < gap; g++) begin
          tick(); cyc++;
        end
        mem_rvalid = 1'b1; mem_rdata = base * (b + 1);
        tick(); cyc++;
        mem_rvalid = 1'b0;
      end
      for (int i = 0; i < 20 && !cpu_valid; i++) begin
        tick(); cyc++;
      end
    end
    if (cpu_valid) begin
      ok = 1;
      rd = cpu_rdata;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++;
    if (cpu_valid !== 1'b0 || cpu_busy !== 1'b0 || mem_req !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ctl: valid=%b busy=%b mreq=%b want 0 0 0",
               cpu_valid, cpu_busy, mem_req);
    end
    n_vec++;
    if (cpu_rdata !== 32'h0 || mem_addr !== 32'h0) begin
      n_err++;
      $display("FAIL reset_data: rdata=%h maddr=%h want 0 0",
               cpu_rdata, mem_addr);
    end
    n_vec++;
    if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL reset_cnt: hit=%0d miss=%0d want 0 0",
               hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_miss_hit();
    int cyc; logic [31:0] rd, ma; bit ms, st, ok;
    fetch(32'h40, 32'h11, 0, 0, cyc, rd, ma, ms, st, ok);
    n_vec++;
    if (!ms || ma !== 32'h40) begin
      n_err++;
      $display("FAIL miss_addr: missed=%b maddr=%h want 1 00000040",
               ms, ma);
    end
    n_vec++;
    if (!ok || rd !== 32'h11 || cyc != 7) begin
      n_err++;
      $display("FAIL miss_resp: ok=%b rdata=%h cyc=%0d want 1 11 7",
               ok, rd, cyc);
    end
    n_vec++;
    if (miss_cnt !== 16'd1 || hit_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL miss_cnt: miss=%0d hit=%0d want 1 0",
               miss_cnt, hit_cnt);
    end
    tick();
    n_vec++;
    if (cpu_valid !== 1'b0 || cpu_busy !== 1'b0 || cpu_rdata !== 32'h11) begin
      n_err++;
      $display("FAIL miss_pulse: valid=%b busy=%b rdata=%h want 0 0 11",
               cpu_valid, cpu_busy, cpu_rdata);
    end
    fetch(32'h48, 32'h0, 0, 0, cyc, rd, ma, ms, st, ok);
    n_vec++;
    if (ms || !ok || rd !== 32'h33 || cyc != 1) begin
      n_err++;
      $display("FAIL hit_48: missed=%b ok=%b rdata=%h cyc=%0d want 0 1 33 1",
               ms, ok, rd, cyc);
    end
    n_vec++;
    if (hit_cnt !== 16'd1 || miss_cnt !== 16'd1) begin
      n_err++;
      $display("FAIL hit_cnt: hit=%0d miss=%0d want 1 1",
               hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_slow_mem();
    int cyc; logic [31:0] rd, ma; bit ms, st, ok;
    apply_reset();
    fetch(32'h4C, 32'hA0, 5, 2, cyc, rd, ma, ms, st, ok);
    n_vec++;
    if (!ms || !st || ma !== 32'h40) begin
      n_err++;
      $display("FAIL slow_req: missed=%b stable=%b maddr=%h want 1 1 00000040",
               ms, st, ma);
    end
    n_vec++;
    if (!ok || rd !== 32'h280 || cyc != 20) begin
      n_err++;
      $display("FAIL slow_resp: ok=%b rdata=%h cyc=%0d want 1 280 20",
               ok, rd, cyc);
    end
  endtask

  task automatic test_lru();
    int cyc; logic [31:0] rd, ma; bit ms, st, ok;
    apply_reset();
    fetch(32'h000, 32'h1000, 0, 0, cyc, rd, ma, ms, st, ok);
    fetch(32'h080, 32'h1080, 0, 0, cyc, rd, ma, ms, st, ok);
    fetch(32'h100, 32'h1100, 0, 0, cyc, rd, ma, ms, st, ok);
    fetch(32'h180, 32'h1180, 0, 0, cyc, rd, ma, ms, st, ok);
    n_vec++;
    if (!ms || rd !== 32'h1180 || miss_cnt !== 16'd4) begin
      n_err++;
      $display("FAIL lru_fill: missed=%b rdata=%h miss=%0d want 1 1180 4",
               ms, rd, miss_cnt);
    end
    fetch(32'h000, 32'h0, 0, 0, cyc, rd, ma, ms, st, ok);
    n_vec++;
    if (ms || rd !== 32'h1000) begin
      n_err++;
      $display("FAIL lru_hit0: missed=%b rdata=%h want 0 1000", ms, rd);
    end
    fetch(32'h200, 32'h1200, 0, 0, cyc, rd, ma, ms, st, ok);
    n_vec++;
    if (!ms || ma !== 32'h200 || rd !== 32'h1200) begin
      n_err++;
      $display("FAIL lru_200: missed=%b maddr=%h rdata=%h want 1 200 1200",
               ms, ma, rd);
    end
    fetch(32'h000, 32'h0, 0, 0, cyc, rd, ma, ms, st, ok);
    n_vec++;
    if (ms || rd !== 32'h1000) begin
      n_err++;
      $display("FAIL lru_keep0: missed=%b rdata=%h want 0 1000", ms, rd);
    end
    fetch(32'h080, 32'h2080, 0, 0, cyc, rd, ma, ms, st, ok);
    n_vec++;
    if (!ms || rd !== 32'h2080) begin
      n_err++;
      $display("FAIL lru_evict80: missed=%b rdata=%h want 1 2080", ms, rd);
    end
    fetch(32'h180, 32'h0, 0, 0, cyc, rd, ma, ms, st, ok);
    n_vec++;
    if (ms || rd !== 32'h1180) begin
      n_err++;
      $display("FAIL lru_keep180: missed=%b rdata=%h want 0 1180", ms, rd);
    end
    n_vec++;
    if (hit_cnt !== 16'd3 || miss_cnt !== 16'd6) begin
      n_err++;
      $display("FAIL lru_cnt: hit=%0d miss=%0d want 3 6", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_flush();
    int cyc, bc; logic [31:0] rd, ma; bit ms, st, ok;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bc = 0;
    while (cpu_busy && bc < 50) begin
      bc++;
      tick();
    end
    n_vec++;
    if (bc != 9) begin
      n_err++;
      $display("FAIL flush_busy: cycles=%0d want 9", bc);
    end
    n_vec++;
    if (hit_cnt !== 16'd3 || miss_cnt !== 16'd6) begin
      n_err++;
      $display("FAIL flush_cnt: hit=%0d miss=%0d want 3 6", hit_cnt, miss_cnt);
    end
    fetch(32'h180, 32'h3180, 0, 0, cyc, rd, ma, ms, st, ok);
    n_vec++;
    if (!ms || rd !== 32'h3180 || miss_cnt !== 16'd7) begin
      n_err++;
      $display("FAIL flush_miss: missed=%b rdata=%h miss=%0d want 1 3180 7",
               ms, rd, miss_cnt);
    end
  endtask

  task automatic test_flush_req();
    int cyc, bc; logic [31:0] rd, ma; bit ms, st, ok, sawv;
    cpu_req = 1'b1; cpu_addr = 32'h180; flush = 1'b1;
    tick();
    cpu_req = 1'b0; flush = 1'b0;
    bc = 0; sawv = 0;
    while (cpu_busy && bc < 50) begin
      bc++;
      tick();
      if (cpu_valid) sawv = 1;
    end
    n_vec++;
    if (bc != 9 || sawv) begin
      n_err++;
      $display("FAIL flush_req: busy=%0d sawvalid=%b want 9 0", bc, sawv);
    end
    n_vec++;
    if (hit_cnt !== 16'd3 || miss_cnt !== 16'd7) begin
      n_err++;
      $display("FAIL flush_req_cnt: hit=%0d miss=%0d want 3 7",
               hit_cnt, miss_cnt);
    end
    fetch(32'h180, 32'h4180, 0, 0, cyc, rd, ma, ms, st, ok);
    n_vec++;
    if (!ms || rd !== 32'h4180) begin
      n_err++;
      $display("FAIL flush_req_miss: missed=%b rdata=%h want 1 4180", ms, rd);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, w; logic [31:0] rd, ma; bit ms, st, ok;
    cpu_req = 1'b1; cpu_addr = 32'h40;
    tick();
    cpu_req = 1'b0;
    w = 0;
    while (!mem_req && w < 20) begin
      tick(); w++;
    end
    n_vec++;
    if (!mem_req) begin
      n_err++;
      $display("FAIL rmid_req: mem_req=%b want 1", mem_req);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h77; tick();
    mem_rdata = 32'h88; tick();
    mem_rdata = 32'h99;
    #2;
    reset = 1'b0;
    #1;
    n_vec++;
    if (cpu_busy !== 1'b0 || mem_req !== 1'b0 || cpu_valid !== 1'b0 ||
        cpu_rdata !== 32'h0 || mem_addr !== 32'h0 ||
        hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL rmid_outs: busy=%b mreq=%b valid=%b rdata=%h maddr=%h hit=%0d miss=%0d want all 0",
               cpu_busy, mem_req, cpu_valid, cpu_rdata, mem_addr,
               hit_cnt, miss_cnt);
    end
    mem_rvalid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    fetch(32'h40, 32'h500, 0, 0, cyc, rd, ma, ms, st, ok);
    n_vec++;
    if (!ms || !ok || rd !== 32'h500 || miss_cnt !== 16'd1) begin
      n_err++;
      $display("FAIL rmid_refill: missed=%b ok=%b rdata=%h miss=%0d want 1 1 500 1",
               ms, ok, rd, miss_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int cyc; logic [31:0] rd, ma; bit ms, st, ok;
    logic [31:0] addrs [3];
    logic [31:0] exp [3];
    addrs[0] = 32'h44; addrs[1] = 32'h48; addrs[2] = 32'h4C;
    exp[0] = 32'hA00; exp[1] = 32'hF00; exp[2] = 32'h1400;
    for (int i = 0; i < 3; i++) begin
      fetch(addrs[i], 32'h0, 0, 0, cyc, rd, ma, ms, st, ok);
      n_vec++;
      if (ms || !ok || rd !== exp[i] || cyc != 1) begin
        n_err++;
        $display("FAIL b2b_%0d: missed=%b ok=%b rdata=%h cyc=%0d want 0 1 %h 1",
                 i, ms, ok, rd, cyc, exp[i]);
      end
    end
    n_vec++;
    if (hit_cnt !== 16'd3 || miss_cnt !== 16'd1) begin
      n_err++;
      $display("FAIL b2b_cnt: hit=%0d miss=%0d want 3 1", hit_cnt, miss_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_miss_hit();
    test_slow_mem();
    test_lru();
    test_flush();
    test_flush_req();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
